nibble_serial_adder: RTL and testbench

Multi-word addition sequencer built around a single 4-bit ripple-carry slice. It accepts W-bit operands over a valid/ready handshake. It then adds them one nibble per clock, least-significant nibble first, with the slice carry registered between nibbles. It returns a (W+1)-bit sum over a second valid/ready handshake. It is the team's way to add operands wider than 4 bits without widening the adder datapath.

---
 rtl/nibble_serial_adder.sv | 124 ++++++++++++
 tb/tb_nibble_serial_adder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// Multi-word adder that reuses one 4-bit ripple-carry slice, one nibble per clock,
// with the carry registered between nibbles and valid/ready handshakes on both sides.
module nibble_serial_adder #(
    parameter int NIBBLES = 4,
    localparam int W = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W:0]   s,
    output logic         busy
);

    // A single-nibble configuration still needs a one-bit index register (held at zero).
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADD  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state;
    logic [W-1:0]     op_x;
    logic [W-1:0]     op_y;
    logic             c_reg;
    logic [IDX_W-1:0] idx;
    logic [W:0]       s_reg;

    logic [3:0]       x_nib;
    logic [3:0]       y_nib;
    logic [3:0]       s4;
    logic [4:0]       carry;
    logic             co;
    logic             last;
    logic [W:0]       s_next;

    assign last = (idx == LAST_IDX);

    always_comb begin
        x_nib = '0;
        y_nib = '0;
        for (int n = 0; n < NIBBLES; n++) begin
            if (idx == IDX_W'(n)) begin
                x_nib = op_x[4*n +: 4];
                y_nib = op_y[4*n +: 4];
            end
        end
    end

    // Same full-adder equations as the standalone 4-bit RCA: sum = parity, carry = majority.
    always_comb begin
        s4       = '0;
        carry    = '0;
        carry[0] = c_reg;
        for (int i = 0; i < 4; i++) begin
            s4[i]      = x_nib[i] ^ y_nib[i] ^ carry[i];
            carry[i+1] = (x_nib[i] & y_nib[i]) | (x_nib[i] & carry[i]) | (y_nib[i] & carry[i]);
        end
        co = carry[4];
    end

    always_comb begin
        s_next = s_reg;
        for (int n = 0; n < NIBBLES; n++) begin
            if (idx == IDX_W'(n)) begin
                s_next[4*n +: 4] = s4;
            end
        end
        if (last) begin
            s_next[W] = co;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            op_x  <= '0;
            op_y  <= '0;
            c_reg <= 1'b0;
            idx   <= '0;
            s_reg <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_x  <= x;
                        op_y  <= y;
                        c_reg <= cin;
                        idx   <= '0;
                        s_reg <= '0;
                        state <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    s_reg <= s_next;
                    c_reg <= co;
                    if (last) begin
                        state <= ST_DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state == ST_ADD) || (state == ST_DONE);
    assign s         = s_reg;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench: a 4-nibble instance for directed handshake tests plus 1- and
// 8-nibble instances driven in lockstep for the random sweep.
module tb_nibble_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x;
    logic [15:0] y;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] s;
    logic        busy;

    logic        sw_valid;
    logic        sw_out_ready;
    logic [31:0] sw_x;
    logic [31:0] sw_y;
    logic        sw_cin;
    logic        ready1, valid1, busy1;
    logic        ready8, valid8, busy8;
    logic [4:0]  s1;
    logic [32:0] s8;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];
    logic [63:0] q1[$];
    logic [63:0] q8[$];

    nibble_serial_adder #(.NIBBLES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .busy(busy)
    );

    nibble_serial_adder #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(ready1),
        .x(sw_x[3:0]), .y(sw_y[3:0]), .cin(sw_cin), .out_valid(valid1),
        .out_ready(sw_out_ready), .s(s1), .busy(busy1)
    );

    nibble_serial_adder #(.NIBBLES(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(ready8),
        .x(sw_x), .y(sw_y), .cin(sw_cin), .out_valid(valid8),
        .out_ready(sw_out_ready), .s(s8), .busy(busy8)
    );

    function automatic logic [63:0] refSum(input logic [63:0] a, input logic [63:0] b, input logic c);
        return a + b + {63'd0, c};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one operand pair to the 4-nibble instance and returns just after the accept edge.
    task automatic applyStimulus(input logic [15:0] ax, input logic [15:0] ay, input logic ac);
        int k;
        x = ax;
        y = ay;
        cin = ac;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 50) begin
            tick();
            k++;
        end
        tick();
        exp_q.push_back(refSum({48'd0, ax}, {48'd0, ay}, ac));
        in_valid = 1'b0;
    endtask

    task automatic waitResult(input int exp_lat, input int exp_busy);
        int lat;
        int busy_cnt;
        logic [63:0] e;
        lat = 0;
        busy_cnt = busy ? 1 : 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
            if (busy) busy_cnt++;
        end
        checkOutput("latency", lat, exp_lat);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checkOutput("sum", {47'd0, s}, e);
        if (out_ready) begin
            tick();
            if (busy) busy_cnt++;
            checkOutput("busy_cycles", busy_cnt, exp_busy);
            checkOutput("idle_ready", {63'd0, in_ready}, 64'd1);
            checkOutput("idle_no_valid", {63'd0, out_valid}, 64'd0);
        end
    endtask

    task automatic runSweep();
        int l1, l8, k;
        logic [63:0] e;
        for (int i = 0; i < 1000; i++) begin
            sw_x = $urandom();
            sw_y = $urandom();
            sw_cin = 1'($urandom_range(0, 1));
            sw_valid = 1'b1;
            tick();
            sw_valid = 1'b0;
            q1.push_back(refSum({60'd0, sw_x[3:0]}, {60'd0, sw_y[3:0]}, sw_cin));
            q8.push_back(refSum({32'd0, sw_x}, {32'd0, sw_y}, sw_cin));
            sw_x = $urandom();
            sw_y = $urandom();
            l1 = -1;
            l8 = -1;
            k = 0;
            while ((l1 < 0 || l8 < 0) && k < 40) begin
                tick();
                k++;
                if (valid1 && l1 < 0) begin
                    l1 = k;
                    e = (q1.size() > 0) ? q1.pop_front() : 'x;
                    checkOutput("n1_sum", {59'd0, s1}, e);
                end
                if (valid8 && l8 < 0) begin
                    l8 = k;
                    e = (q8.size() > 0) ? q8.pop_front() : 'x;
                    checkOutput("n8_sum", {31'd0, s8}, e);
                end
            end
            checkOutput("n1_latency", l1, 1);
            checkOutput("n8_latency", l8, 8);
            tick();
        end
    endtask

    initial begin
        logic [63:0] held;
        logic [63:0] e;
        logic saw_valid;
        logic acc;
        int sent, got, last_acc, cyc;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        x = '0;
        y = '0;
        cin = 1'b0;
        sw_valid = 1'b0;
        sw_out_ready = 1'b1;
        sw_x = '0;
        sw_y = '0;
        sw_cin = 1'b0;

        tick();
        tick();
        checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd1);
        checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("rst_busy", {63'd0, busy}, 64'd0);
        checkOutput("rst_s", {47'd0, s}, 64'd0);
        checkOutput("rst_ready1", {63'd0, ready1}, 64'd1);
        checkOutput("rst_ready8", {63'd0, ready8}, 64'd1);
        rst = 1'b0;
        tick();

        applyStimulus(16'h0005, 16'h0006, 1'b0);
        waitResult(4, 5);
        checkOutput("hold_in_idle", {47'd0, s}, 64'h0000B);

        applyStimulus(16'hFFFF, 16'h0001, 1'b0);
        waitResult(4, 5);
        checkOutput("ripple_all", {47'd0, s}, 64'h10000);
        applyStimulus(16'hFFFF, 16'hFFFF, 1'b1);
        waitResult(4, 5);
        checkOutput("max_sum", {47'd0, s}, 64'h1FFFF);

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(16'h1234, 16'h4321, 1'b0);
        held = refSum(64'h1234, 64'h4321, 1'b0);
        waitResult(4, 5);
        x = 16'hAAAA;
        y = 16'h0F0F;
        cin = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput("bp_out_valid", {63'd0, out_valid}, 64'd1);
            checkOutput("bp_in_ready", {63'd0, in_ready}, 64'd0);
            checkOutput("bp_s_stable", {47'd0, s}, held);
        end
        out_ready = 1'b1;
        tick();
        checkOutput("bp_release_ready", {63'd0, in_ready}, 64'd1);
        checkOutput("bp_release_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("bp_release_s", {47'd0, s}, held);
        applyStimulus(16'hAAAA, 16'h0F0F, 1'b1);
        checkOutput("bp_pending_busy", {63'd0, busy}, 64'd1);
        waitResult(4, 5);

        $display("[TB] reset mid-operation");
        applyStimulus(16'h0F0F, 16'h0101, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abort_in_ready", {63'd0, in_ready}, 64'd1);
        checkOutput("abort_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("abort_busy", {63'd0, busy}, 64'd0);
        checkOutput("abort_s", {47'd0, s}, 64'd0);
        saw_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) saw_valid = 1'b1;
        end
        checkOutput("abort_no_valid", {63'd0, saw_valid}, 64'd0);
        exp_q.delete();
        applyStimulus(16'h8001, 16'h7FFF, 1'b0);
        waitResult(4, 5);

        $display("[TB] back-to-back");
        sent = 0;
        got = 0;
        last_acc = 0;
        cyc = 0;
        x = 16'($urandom());
        y = 16'($urandom());
        cin = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
        while (got < 8 && cyc < 300) begin
            acc = in_valid && in_ready;
            tick();
            cyc++;
            if (acc) begin
                exp_q.push_back(refSum({48'd0, x}, {48'd0, y}, cin));
                if (sent > 0) checkOutput("b2b_spacing", cyc - last_acc, 6);
                last_acc = cyc;
                sent++;
                if (sent < 8) begin
                    x = 16'($urandom());
                    y = 16'($urandom());
                    cin = 1'($urandom_range(0, 1));
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                checkOutput("b2b_sum", {47'd0, s}, e);
                got++;
            end
        end
        checkOutput("b2b_count", got, 8);

        $display("[TB] random sweep NIBBLES=1 and NIBBLES=8");
        runSweep();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
